// File: rtl/uart_tx_byte_if.sv
// Handshake and line signals between the button edge stage, the UART
// transmitter and the TX pin.
interface uart_tx_byte_if;
   logic       trig;
   logic [7:0] data;
   logic       tx;
   logic       busy;
   logic       done;

   // Requester side: raises trig with a byte, watches the line and status.
   modport master (output trig, data, input tx, busy, done);
   // Transmitter side.
   modport slave  (input trig, data, output tx, busy, done);
endinterface

// File: rtl/uart_tx_byte.sv
// One-byte asynchronous UART transmitter: start bit, 8 data bits LSB first,
// optional even/odd parity, one stop bit. All outputs are registered.
module uart_tx_byte #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600,
   parameter int PARITY   = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_byte_if.slave  bus
);

   localparam int DIV    = CLK_FREQ / BAUD;
   localparam int CNT_W  = $clog2(DIV);
   localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
   localparam bit PAR_ODD = (PARITY == 2);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [7:0]       shift;
   logic             par_bit;
   logic             tx_q;
   logic             busy_q;
   logic             done_q;

   // Last cycle of the current bit period.
   logic cnt_last;
   assign cnt_last = (cnt == CNT_W'(DIV - 1));

   // Frame sequencer; tx, busy and done are produced directly as registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every branch sees the pre-edge
         // values of state, cnt and shift regardless of statement order.
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.trig) begin
                  shift   <= bus.data;
                  cnt     <= '0;
                  idx     <= '0;
                  par_bit <= PAR_ODD ? ~^bus.data : ^bus.data;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state   <= START;
               end
            end
            START: begin
               if (cnt_last) begin
                  cnt   <= '0;
                  tx_q  <= shift[0];
                  state <= DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt_last) begin
                  cnt   <= '0;
                  shift <= shift >> 1;
                  if (idx == 3'd7) begin
                     if (PAR_EN) begin
                        tx_q  <= par_bit;
                        state <= PAR;
                     end else begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                     end
                  end else begin
                     idx  <= idx + 1'b1;
                     tx_q <= shift[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PAR: begin
               if (cnt_last) begin
                  cnt   <= '0;
                  tx_q  <= 1'b1;
                  state <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt_last) begin
                  cnt    <= '0;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               tx_q   <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.tx   = tx_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

endmodule
